// File: rtl/bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_arbiter
//  Purpose  : Registered round-robin shared-bus driver with lock support.
//  Revision : 1.0  initial release
// ============================================================================
module bus_arbiter #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] in,
  input  logic [CHANNELS-1:0]       req,
  input  logic [CHANNELS-1:0]       lock,
  output logic [CHANNELS-1:0]       grant,
  output logic [WIDTH-1:0]          bus,
  output logic                      bus_valid,
  output logic                      conflict,
  output logic [CNT_W-1:0]          conflict_cnt
);

  localparam int PTR_W = $clog2(CHANNELS);

  logic [PTR_W-1:0]    r_ptr;
  logic [CHANNELS-1:0] r_grant;
  logic [WIDTH-1:0]    r_bus;
  logic                r_valid;
  logic                r_conflict;
  logic [CNT_W-1:0]    r_cnt;

  logic                w_locked;
  logic [WIDTH-1:0]    w_lock_data;
  logic                w_found;
  logic [CHANNELS-1:0] w_sel_grant;
  logic [WIDTH-1:0]    w_sel_data;
  logic [PTR_W-1:0]    w_next_ptr;
  logic                w_seen;
  logic                w_multi;

  always_comb begin : p_decide
    int idx;
    idx         = 0;
    w_locked    = 1'b0;
    w_lock_data = '0;
    w_found     = 1'b0;
    w_sel_grant = '0;
    w_sel_data  = '0;
    w_next_ptr  = r_ptr;
    w_seen      = 1'b0;
    w_multi     = 1'b0;

    // grant is one-hot, so at most one channel can satisfy the lock test
    for (int k = 0; k < CHANNELS; k++) begin
      if (r_grant[k] && req[k] && lock[k]) begin
        w_locked    = 1'b1;
        w_lock_data = in[k*WIDTH +: WIDTH];
      end
    end

    for (int i = 0; i < CHANNELS; i++) begin
      idx = int'(r_ptr) + i;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!w_found && req[idx]) begin
        w_found          = 1'b1;
        w_sel_grant[idx] = 1'b1;
        w_sel_data       = in[idx*WIDTH +: WIDTH];
        w_next_ptr       = (idx == CHANNELS - 1) ? '0 : PTR_W'(idx + 1);
      end
    end

    for (int j = 0; j < CHANNELS; j++) begin
      if (req[j]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_bus      <= '0;
      r_valid    <= 1'b0;
      r_conflict <= 1'b0;
      r_cnt      <= '0;
    end else begin
      r_conflict <= w_multi;
      if (w_multi && (r_cnt != {CNT_W{1'b1}})) r_cnt <= r_cnt + CNT_W'(1);

      if (w_locked) begin
        r_bus   <= w_lock_data;
        r_valid <= 1'b1;
      end else if (w_found) begin
        r_grant <= w_sel_grant;
        r_bus   <= w_sel_data;
        r_ptr   <= w_next_ptr;
        r_valid <= 1'b1;
      end else begin
        // idle: bus deliberately keeps its last value
        r_grant <= '0;
        r_valid <= 1'b0;
      end
    end
  end

  assign grant        = r_grant;
  assign bus          = r_bus;
  assign bus_valid    = r_valid;
  assign conflict     = r_conflict;
  assign conflict_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/bus_arbiter.md
# bus_arbiter

Parametrised, registered shared-bus driver for the 16-bit CPU datapath. It replaces the per-source enabled bus buffers: CHANNELS sources each present WIDTH-bit data and a request, and a round-robin arbiter with lock support selects exactly one source per cycle. The block drives a single registered bus with a valid flag instead of tri-state outputs, so it never has contention or floating values. It sits between the register file, ALU and memory-data sources and the internal CPU bus.

## Interface
- WIDTH, 16, bus and per-channel data width (≥1)
- CHANNELS, 4, number of sources (2..16)
- CNT_W, 8, width of the saturating contention counter
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in  in  CHANNELS*WIDTH  channel data, flattened; channel k = in[k*WIDTH +: WIDTH]
- req  in  CHANNELS  per-channel bus request
- lock  in  CHANNELS  per-channel lock; meaningful only for the currently granted channel
- grant  out  CHANNELS  registered one-hot grant, all-zero when idle
- bus  out  WIDTH  registered bus value
- bus_valid  out  1  registered; high when bus carries granted data
- conflict  out  1  registered; high when ≥2 req bits were set at the last edge
- conflict_cnt  out  CNT_W  saturating count of conflict cycles since reset

## Operation
- One clock and one synchronous active-high reset. rst has priority over all other inputs.
- Internal state: round-robin pointer ptr (clog2(CHANNELS) bits), grant, bus, bus_valid, conflict, conflict_cnt.
- Reset values: ptr=0, grant=0, bus=0, bus_valid=0, conflict=0, conflict_cnt=0.
- Per-edge decision (not in reset):
  - LOCKED: current grant has channel g, req[g]=1 and lock[g]=1 → keep g, ptr unchanged, regardless of other requests.
  - ARBITRATE: otherwise, if any req bit is set → grant the first requesting channel searching ptr, ptr+1, …, wrapping modulo CHANNELS; then ptr = granted index + 1 (mod CHANNELS).
  - IDLE: no req bit set and not locked → grant=0, bus_valid=0, bus holds its last value, ptr unchanged.
- Whenever a channel k is granted at an edge, bus captures in[k] at that same edge. A held or locked grant recaptures every cycle, so bus follows channel data with a 1-cycle lag.
- When a granted channel drops req, it loses the grant at the next edge even if lock=1.
- lock on a non-granted channel has no effect.
- conflict = (popcount(req) ≥ 2), registered. conflict_cnt increments when conflict is computed high and saturates at 2^CNT_W−1. It never wraps.
- grant is one-hot or zero at all times. bus_valid equals |grant.

## Timing
- Latency: req/in sampled at edge N → grant, bus, bus_valid and conflict are valid after edge N. There is no combinational path from inputs to outputs.
- Throughput: a new channel can be granted every cycle. Back-to-back grants to different channels need no idle cycle.
- Round-robin fairness without lock: any continuously requesting channel is granted within CHANNELS cycles.
- Lock: a locking channel may hold the bus indefinitely. Fairness is suspended while it does.
- Reset asserted mid-transfer or mid-lock: all outputs take their reset values after that edge. The first grant after rst deasserts searches from channel 0.
- Simultaneous lock release and new requests: the edge where lock[g] or req[g] falls performs a normal ARBITRATE from the current ptr (ptr already points past g).
- Wrap-around: with ptr=CHANNELS−1 and only channel 0 requesting, channel 0 is granted and ptr becomes 1.

## Test plan
- Reset: hold rst 2 cycles with req=4'b1111 → grant=0, bus=0, bus_valid=0, conflict=0, conflict_cnt=0. First edge after release → grant=4'b0001, ptr=1.
- Round-robin: req=4'b1111 continuously, in[k]=16'hA000+k → grant sequence 0001, 0010, 0100, 1000, 0001; bus sequence A000, A001, A002, A003, A000; conflict=1 each cycle.
- Lock: grant on ch2, then lock[2]=1 and req=4'b1111 for 5 cycles → grant stays 0100. Change in[2] from 16'h1234 to 16'h5678 → bus shows 5678 one cycle later. Drop lock[2] → next grant is 1000.
- Idle/hold: ch1 granted with bus=16'hBEEF, then req=0 → grant=0, bus_valid=0, bus stays BEEF. Then req=4'b0001 → grant=0001 next edge.
- Saturation: CNT_W=2 and 5 consecutive cycles with req=4'b0011 → conflict_cnt goes 1, 2, 3, 3, 3.
- Reset mid-lock: ch3 locked, rst pulsed 1 cycle → all outputs at reset values. Then req=4'b1000 → grant=1000.
